// File: rtl/status_reporter.sv
// status_reporter: watches a status vector and reports it as an ASCII line
// "L:" + STATUS_W chars '0'/'1' (MSB first) + CR + LF on a valid/ready byte
// stream feeding a UART transmitter.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   status    in   STATUS_W-bit vector to report (synchronous to clk)
//   query     in   single-cycle report request
//   tx_data   out  byte to the transmitter
//   tx_valid  out  tx_data holds a valid byte
//   tx_ready  in   transmitter accepts; transfer on edge with tx_valid & tx_ready
//   busy      out  high while a frame is in progress
module status_reporter #(
  parameter int unsigned STATUS_W       = 5,
  parameter bit          SEND_ON_CHANGE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [STATUS_W-1:0] status,
  input  logic                query,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy
);

  localparam int unsigned FRAME_LEN = STATUS_W + 4;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [STATUS_W-1:0] last_q, last_d;
  logic [STATUS_W-1:0] snap_q, snap_d;
  logic                pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
  logic                new_req;

  // Byte at position idx of the frame reporting snap.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0]    idx,
                                            input logic [STATUS_W-1:0] snap);
    logic [7:0] b;
    b = 8'h00;
    if (idx == '0) begin
      b = 8'h4C;
    end else if (idx == IDX_W'(1)) begin
      b = 8'h3A;
    end else if (idx == IDX_W'(STATUS_W + 2)) begin
      b = 8'h0D;
    end else if (idx == IDX_W'(STATUS_W + 3)) begin
      b = 8'h0A;
    end else begin
      // Character at idx reports bit STATUS_W+1-idx, so the MSB goes first.
      for (int unsigned i = 0; i < STATUS_W; i++) begin
        if (idx == IDX_W'(STATUS_W + 1 - i)) begin
          b = snap[i] ? 8'h31 : 8'h30;
        end
      end
    end
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    last_d     = status;
    // A change and a query on the same edge merge into one request.
    new_req    = query | (SEND_ON_CHANGE && (status != last_q));
    pending_d  = pending_q | new_req;

    case (state_q)
      StIdle: begin
        if (pending_q) begin
          snap_d     = last_q;
          idx_d      = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h4C;
          busy_d     = 1'b1;
          state_d    = StSend;
          // The request being served is consumed; only a fresh one survives.
          pending_d  = new_req;
        end
      end
      StSend: begin
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = StIdle;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = frame_byte(idx_q + IDX_W'(1), snap_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_q     <= '0;
      snap_q     <= '0;
      pending_q  <= 1'b0;
      idx_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      snap_q     <= snap_d;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

endmodule
